// File: rtl/serial_to_parallel_pkg.sv
// Shared types and defaults for the serial-to-parallel deserializer.
package sp_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } sp_state_t;

  localparam int unsigned DEFAULT_DATA_W = 4;

endpackage

// File: rtl/serial_to_parallel_if.sv
// Serial input side plus the word-level valid/ready output of the deserializer.
interface serial_to_parallel_if
  import sp_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
);

  logic              serial_i;
  logic              valid_i;
  logic [DATA_W-1:0] parallel_o;
  logic              valid_o;
  logic              ready_i;
  logic              busy_o;
  logic              overrun_o;

  // Producer/consumer view (drives serial bits and ready).
  modport master (
    output serial_i,
    output valid_i,
    output ready_i,
    input  parallel_o,
    input  valid_o,
    input  busy_o,
    input  overrun_o
  );

  // Deserializer view.
  modport slave (
    input  serial_i,
    input  valid_i,
    input  ready_i,
    output parallel_o,
    output valid_o,
    output busy_o,
    output overrun_o
  );

endinterface

// File: rtl/serial_to_parallel_out_buf.sv
// One-entry valid/ready holding register; flags a sticky overrun when a
// completed word arrives while an unconsumed word is still held.
module sp_out_buf
  import sp_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] parallel_o,
  output logic              valid_o,
  output logic              overrun_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  // Next-state: load on free or draining slot, drop and flag otherwise.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load_i) begin
      if (!valid_q || ready_i) begin
        data_d  = word_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Holding register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign parallel_o = data_q;
  assign valid_o    = valid_q;
  assign overrun_o  = overrun_q;

endmodule

// File: rtl/serial_to_parallel.sv
// Reassembles an LSB-first serial bit stream into DATA_W-bit words.
module serial_to_parallel
  import sp_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input logic                 clk,
  input logic                 reset,
  serial_to_parallel_if.slave bus
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  sp_state_t         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // The oldest bit of a DATA_W-wide shifter would be shifted out unread, so
  // only the DATA_W-1 most recent bits are kept.
  logic [DATA_W-2:0] shift_q, shift_d;
  logic [DATA_W-1:0] word;
  logic              load;

  assign word = {bus.serial_i, shift_q};

  // Next-state: shift on each valid bit, complete on the DATA_W-th.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          shift_d = word[DATA_W-1:1];
          cnt_d   = CntW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.valid_i) begin
          shift_d = word[DATA_W-1:1];
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            state_d = IDLE;
            load    = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and shifter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign bus.busy_o = (cnt_q != '0);

  sp_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .word_i     (word),
    .ready_i    (bus.ready_i),
    .parallel_o (bus.parallel_o),
    .valid_o    (bus.valid_o),
    .overrun_o  (bus.overrun_o)
  );

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench: expected words are queued as they are sent and
// compared whenever the DUT hands a word over.
module tb_serial_to_parallel;
  import sp_pkg::*;

  localparam int unsigned DataW = 4;

  logic clk;
  logic reset;

  serial_to_parallel_if #(.DATA_W(DataW)) bus ();

  serial_to_parallel #(
    .DATA_W (DataW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned n_xfers;
  logic [DataW-1:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Consumer side: a handshake seen before the edge pops one expected word.
  always @(negedge clk) begin
    if (!reset && bus.valid_o && bus.ready_i) begin
      n_xfers++;
      if (exp_q.size() == 0) check_eq("unexpected_word", 32'(bus.parallel_o), 32'hdead);
      else check_eq("word", 32'(bus.parallel_o), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.serial_i = b;
    bus.valid_i  = 1'b1;
    tick();
    bus.valid_i  = 1'b0;
    bus.serial_i = 1'b0;
  endtask

  task automatic send_word(input logic [DataW-1:0] w, input bit delivered);
    if (delivered) exp_q.push_back(w);
    for (int i = 0; i < int'(DataW); i++) send_bit(w[i]);
  endtask

  initial begin
    int unsigned xf0;
    n_checks     = 0;
    n_errors     = 0;
    n_xfers      = 0;
    reset        = 1'b1;
    bus.serial_i = 1'b0;
    bus.valid_i  = 1'b0;
    bus.ready_i  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_valid", 32'(bus.valid_o), 0);
    check_eq("rst_busy", 32'(bus.busy_o), 0);
    check_eq("rst_overrun", 32'(bus.overrun_o), 0);
    check_eq("rst_parallel", 32'(bus.parallel_o), 0);

    // Single word 0,1,0,1 -> 4'b1010, busy only while partial.
    bus.ready_i = 1'b1;
    exp_q.push_back(4'b1010);
    send_bit(1'b0);
    check_eq("w1_busy1", 32'(bus.busy_o), 1);
    send_bit(1'b1);
    send_bit(1'b0);
    check_eq("w1_busy3", 32'(bus.busy_o), 1);
    check_eq("w1_valid_early", 32'(bus.valid_o), 0);
    send_bit(1'b1);
    check_eq("w1_busy4", 32'(bus.busy_o), 0);
    check_eq("w1_valid", 32'(bus.valid_o), 1);
    check_eq("w1_data", 32'(bus.parallel_o), 32'hA);
    tick();
    check_eq("w1_valid_pulse", 32'(bus.valid_o), 0);

    // Gapped word 1,1,_,_,_,0,1 -> 4'b1011.
    xf0 = n_xfers;
    exp_q.push_back(4'b1011);
    send_bit(1'b1);
    send_bit(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("gap_busy", 32'(bus.busy_o), 1);
      check_eq("gap_valid", 32'(bus.valid_o), 0);
    end
    send_bit(1'b0);
    send_bit(1'b1);
    check_eq("gap_data", 32'(bus.parallel_o), 32'hB);
    tick();
    check_eq("gap_xfers", n_xfers - xf0, 1);

    // Back-to-back words with no bubbles.
    xf0 = n_xfers;
    begin
      logic [DataW-1:0] words [4];
      words = '{4'hA, 4'h5, 4'hF, 4'h0};
      for (int k = 0; k < 4; k++) begin
        send_word(words[k], 1'b1);
        check_eq("b2b_valid", 32'(bus.valid_o), 1);
        check_eq("b2b_data", 32'(bus.parallel_o), 32'(words[k]));
      end
    end
    tick();
    check_eq("b2b_xfers", n_xfers - xf0, 4);
    check_eq("b2b_overrun", 32'(bus.overrun_o), 0);

    // Backpressure: word held stable, released by a one-cycle ready.
    bus.ready_i = 1'b0;
    send_word(4'h3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_valid", 32'(bus.valid_o), 1);
      check_eq("bp_data", 32'(bus.parallel_o), 32'h3);
      tick();
    end
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    check_eq("bp_release", 32'(bus.valid_o), 0);

    // Overrun: second word dropped while first is held.
    send_word(4'h3, 1'b1);
    check_eq("ov_pre", 32'(bus.overrun_o), 0);
    send_word(4'hC, 1'b0);
    check_eq("ov_flag", 32'(bus.overrun_o), 1);
    check_eq("ov_data", 32'(bus.parallel_o), 32'h3);
    bus.ready_i = 1'b1;
    tick();
    check_eq("ov_sticky", 32'(bus.overrun_o), 1);
    check_eq("ov_drained", 32'(bus.valid_o), 0);
    send_word(4'h9, 1'b1);
    check_eq("ov_next_data", 32'(bus.parallel_o), 32'h9);
    check_eq("ov_next_sticky", 32'(bus.overrun_o), 1);
    tick();

    // Reset mid-word with a held word pending.
    bus.ready_i = 1'b0;
    send_word(4'h5, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_valid", 32'(bus.valid_o), 0);
    check_eq("mid_rst_busy", 32'(bus.busy_o), 0);
    check_eq("mid_rst_overrun", 32'(bus.overrun_o), 0);
    check_eq("mid_rst_parallel", 32'(bus.parallel_o), 0);
    bus.ready_i = 1'b1;
    send_word(4'b0001, 1'b1);
    check_eq("post_rst_data", 32'(bus.parallel_o), 32'h1);
    tick();
    tick();
    check_eq("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
- Downstream stage of the 4-bit parallel-to-serial converter. Consumes its serial bit stream (serial_o/valid_o) and reassembles DATA_W-bit words.
- Finished words are presented on a registered valid/ready output with a one-entry holding buffer.
- Sits between the serializer and any word-level consumer.
- Bit order is LSB first, matching the serializer.

Parameters:
- DATA_W, 4, word width in bits (>= 2).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- serial_i  input  1  serial data bit, sampled when valid_i=1.
- valid_i  input  1  serial_i carries a valid bit this cycle.
- parallel_o  output  DATA_W  assembled word, bit 0 = first bit received.
- valid_o  output  1  parallel_o holds an unconsumed word.
- ready_i  input  1  consumer accepts parallel_o when valid_o=1.
- busy_o  output  1  a partial word is in the shift register (bit count != 0).
- overrun_o  output  1  sticky: a completed word was dropped because the buffer was full.

Behaviour:
- Reset: synchronous, active-high, evaluated on the clk rising edge. Clears:
  - parallel_o=0, valid_o=0, busy_o=0, overrun_o=0
  - shift register=0, bit count=0, state=IDLE
  - Applies mid-word and mid-handshake; the partial word and any buffered word are discarded.
- FSM (sp_state_t):
  - IDLE (count==0).
    - valid_i=1: shift in serial_i, count=1, go to SHIFT.
    - Otherwise hold.
  - SHIFT (0<count<DATA_W).
    - valid_i=1: shift_reg <= {serial_i, shift_reg[DATA_W-1:1]}, count++.
    - On the DATA_W-th bit: word complete, count=0, go to IDLE.
    - valid_i=0: hold state, count and shift register. Gaps between bits are legal and never abort a word.
- Completion / output buffer. On the cycle the last bit is sampled, the word is {serial_i, shift_reg[DATA_W-1:1]}.
  - If valid_o=0, or valid_o=1 && ready_i=1: parallel_o <= word, valid_o <= 1 next cycle. Latency is 1 clk after the final bit.
  - If valid_o=1 && ready_i=0: the word is dropped, parallel_o is unchanged, overrun_o <= 1. overrun_o stays high until reset. Counting continues normally.
- Handshake:
  - Transfer occurs when valid_o && ready_i on a clock edge.
  - With no new completion in that cycle, valid_o <= 0 next cycle.
  - parallel_o is stable while valid_o=1 && ready_i=0.
  - valid_o never deasserts without a transfer (except on reset).
- Simultaneous transfer and completion: the new word replaces the old one, valid_o stays 1, no overrun. Sustains one word per DATA_W bits with no bubbles.
- busy_o = (count != 0), registered with the state.
- Counter width is $clog2(DATA_W+1). It wraps to 0 only on completion and never passes DATA_W.
- ready_i is ignored while valid_o=0.

Decomposition:
- Package sp_pkg holds:
  - typedef enum logic {IDLE, SHIFT} sp_state_t
  - localparam DEFAULT_DATA_W = 4
- One natural sub-module, sp_out_buf: the one-entry valid/ready holding register with overrun detection.
  - Inputs: load, word, ready_i.
  - Outputs: parallel_o, valid_o, overrun_o.
  - The top keeps the FSM, counter and shift register.

Test Plan:
- Reset then single word: ready_i=1, bits 0,1,0,1 on 4 consecutive cycles -> parallel_o=4'b1010, valid_o=1 for exactly one cycle, one clk after the 4th bit. busy_o high during cycles 2-4 only.
- Gapped input: bits 1,1,0,1 with valid_i=0 for 3 cycles between bits 2 and 3 -> parallel_o=4'b1011. busy_o stays 1 through the gap. No extra valid_o pulses.
- Back-to-back words with ready_i=1: 16 contiguous bits encoding 4'hA, 4'h5, 4'hF, 4'h0 -> four valid_o pulses, 4 cycles apart, in order. overrun_o=0.
- Backpressure: ready_i=0 while word 4'h3 completes -> valid_o=1 and parallel_o=4'h3 held stable for 10 cycles. Raise ready_i for 1 cycle -> valid_o=0 next cycle.
- Overrun: ready_i=0, send 4'h3 then 4'hC -> parallel_o stays 4'h3, overrun_o=1 from the cycle after the 8th bit and remains 1 after ready_i rises. Send 4'h9 with ready_i=1 -> delivered, overrun_o still 1.
- Reset mid-operation: assert reset after 2 bits of a word, with a held word pending -> next cycle valid_o=0, busy_o=0, overrun_o=0, parallel_o=0. Then 4 bits 1,0,0,0 -> parallel_o=4'b0001.
